// File: rtl/jtframe_prog_pkg.sv
// Types and helpers shared by the ROM-download packer and its write FIFO.
// The SDRAM programming entry stores the word address at its widest supported width.
package jtframe_prog_pkg;

  localparam int PROG_AW = 23;

  typedef struct packed {
    logic [1:0]         ba;
    logic [PROG_AW-1:0] addr;
    logic [15:0]        data;
    logic [1:0]         mask;
  } prog_entry_t;

  typedef enum logic {IDLE, WAIT} prog_state_t;

  function automatic logic [1:0] addr_to_bank(
    input logic [24:0] addr,
    input logic [24:0] ba1_start,
    input logic [24:0] ba2_start,
    input logic [24:0] ba3_start
  );
    if (addr >= ba3_start)      return 2'd3;
    else if (addr >= ba2_start) return 2'd2;
    else if (addr >= ba1_start) return 2'd1;
    else                        return 2'd0;
  endfunction

endpackage

// File: rtl/jtframe_prog_fifo.sv
// Small synchronous FIFO of SDRAM write entries.
// The head is read combinationally so the consumer can load it on the popping edge.
module jtframe_prog_fifo
  import jtframe_prog_pkg::*;
#(
  parameter int AW = 2
)(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_push,
  input  prog_entry_t i_din,
  input  logic        i_pop,
  output prog_entry_t o_dout,
  output logic        o_full,
  output logic        o_empty
);

  localparam int DEPTH = 1 << AW;

  prog_entry_t    r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_pop;
  logic           w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop & ~o_empty;
  // A pop frees the head slot on this edge, so a full FIFO can still accept.
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/jtframe_prog_packer.sv
// Packs the ROM-download byte stream into 16-bit SDRAM writes, buffers them
// and issues them over the prog_we/prog_rdy handshake.
module jtframe_prog_packer
  import jtframe_prog_pkg::*;
#(
  parameter int          SDRAMW    = 23,
  parameter logic [24:0] BA1_START = 25'h10_0000,
  parameter logic [24:0] BA2_START = 25'h18_0000,
  parameter logic [24:0] BA3_START = 25'h1C_0000,
  parameter bit          SWAB      = 1'b0,
  parameter int          FIFO_AW   = 2
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              downloading,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ioctl_wr,
  output logic [SDRAMW-1:0] prog_addr,
  output logic [15:0]       prog_data,
  output logic [1:0]        prog_mask,
  output logic [1:0]        prog_ba,
  output logic              prog_we,
  output logic              prog_rd,
  input  logic              prog_rdy,
  output logic              dwnld_busy,
  output logic              overflow
);

  logic [1:0]        w_ba;
  logic [24:0]       w_start;
  logic [24:0]       w_off;
  logic [SDRAMW-1:0] w_word;

  assign w_ba = addr_to_bank(ioctl_addr, BA1_START, BA2_START, BA3_START);

  always_comb begin
    w_start = '0;
    case (w_ba)
      2'd1:    w_start = BA1_START;
      2'd2:    w_start = BA2_START;
      2'd3:    w_start = BA3_START;
      default: w_start = '0;
    endcase
  end

  assign w_off  = ioctl_addr - w_start;
  assign w_word = SDRAMW'(w_off >> 1);

  logic              r_pend_valid;
  logic [24:0]       r_pend_addr;
  logic [1:0]        r_pend_ba;
  logic [SDRAMW-1:0] r_pend_word;
  logic [7:0]        r_pend_byte;
  logic              w_merge;
  logic              w_flush;
  logic              w_push;
  prog_entry_t       w_entry;

  assign w_merge = ioctl_wr & r_pend_valid & ~r_pend_addr[0] &
                   (ioctl_addr == r_pend_addr + 25'd1) & (w_ba == r_pend_ba);
  assign w_flush = ~ioctl_wr & ~downloading & r_pend_valid;
  assign w_push  = ioctl_wr ? r_pend_valid : w_flush;

  always_comb begin
    w_entry.ba   = r_pend_ba;
    w_entry.addr = PROG_AW'(r_pend_word);
    if (w_merge) begin
      w_entry.data = SWAB ? {r_pend_byte, ioctl_dout} : {ioctl_dout, r_pend_byte};
      w_entry.mask = 2'b00;
    end else begin
      // Lone byte: replicate on both lanes and enable only its own lane.
      w_entry.data = {r_pend_byte, r_pend_byte};
      w_entry.mask = (r_pend_addr[0] ^ SWAB) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_valid <= 1'b0;
    end else if (ioctl_wr) begin
      r_pend_valid <= ~w_merge;
      r_pend_addr  <= ioctl_addr;
      r_pend_ba    <= w_ba;
      r_pend_word  <= w_word;
      r_pend_byte  <= ioctl_dout;
    end else if (w_flush) begin
      r_pend_valid <= 1'b0;
    end
  end

  prog_entry_t w_fifo_dout;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;

  jtframe_prog_fifo #(.AW(FIFO_AW)) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_din   (w_entry),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  prog_state_t r_state;
  prog_state_t w_state_next;
  prog_entry_t r_out;
  logic        r_we;
  logic        r_overflow;

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: if (!w_empty) begin
        w_pop        = 1'b1;
        w_state_next = WAIT;
      end
      WAIT: if (prog_rdy) w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_out      <= '{ba: 2'd0, addr: '0, data: 16'd0, mask: 2'b11};
      r_we       <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) begin
        r_out <= w_fifo_dout;
        r_we  <= 1'b1;
      end else if (r_state == WAIT && prog_rdy) begin
        r_we <= 1'b0;
      end
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign prog_addr  = SDRAMW'(r_out.addr);
  assign prog_data  = r_out.data;
  assign prog_mask  = r_out.mask;
  assign prog_ba    = r_out.ba;
  assign prog_we    = r_we;
  assign prog_rd    = 1'b0;
  assign overflow   = r_overflow;
  assign dwnld_busy = downloading | r_pend_valid | ~w_empty | r_we;

endmodule

// File: tb/tb_jtframe_prog_packer.sv
// Directed bench for jtframe_prog_packer: byte merging, bank mapping, flush,
// FIFO overflow under a stalled controller and reset during a write.
module tb_jtframe_prog_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;
  logic [22:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_ba;
  logic        prog_we;
  logic        prog_rd;
  logic        prog_rdy;
  logic        dwnld_busy;
  logic        overflow;

  int checks = 0;
  int fails  = 0;

  jtframe_prog_packer dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_ba     (prog_ba),
    .prog_we     (prog_we),
    .prog_rd     (prog_rd),
    .prog_rdy    (prog_rdy),
    .dwnld_busy  (dwnld_busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic ack;
    prog_rdy = 1'b1;
    tick();
    prog_rdy = 1'b0;
  endtask

  task automatic wait_we(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (prog_we === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; downloading = 1'b0; ioctl_wr = 1'b0; prog_rdy = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    tick(); tick();
    checks++;
    if ({prog_we, prog_rd, prog_ba, prog_addr, prog_data, prog_mask, dwnld_busy, overflow} !==
        {1'b0, 1'b0, 2'd0, 23'd0, 16'd0, 2'b11, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_outputs: got we=%b rd=%b ba=%0d addr=%h data=%h mask=%b busy=%b ovf=%b required 0 0 0 0 0000 11 0 0",
               prog_we, prog_rd, prog_ba, prog_addr, prog_data, prog_mask, dwnld_busy, overflow);
    end
    rst = 1'b0;
  endtask

  task automatic test_merge;
    downloading = 1'b1;
    strobe(25'h0, 8'hAA);
    strobe(25'h1, 8'h55);
    checks++;
    if (prog_we !== 1'b0) begin
      fails++; $display("FAIL merge_we_early: got %b required 0", prog_we);
    end
    tick();
    checks++;
    if ({prog_we, prog_ba, prog_addr, prog_data, prog_mask} !== {1'b1, 2'd0, 23'd0, 16'h55AA, 2'b00}) begin
      fails++;
      $display("FAIL merge_write: got we=%b ba=%0d addr=%h data=%h mask=%b required 1 0 0 55aa 00",
               prog_we, prog_ba, prog_addr, prog_data, prog_mask);
    end
    ack();
    checks++;
    if (prog_we !== 1'b0) begin
      fails++; $display("FAIL merge_we_clear: got %b required 0", prog_we);
    end
  endtask

  task automatic test_flush;
    strobe(25'h4, 8'h3C);
    downloading = 1'b0;
    tick();
    tick();
    checks++;
    if ({prog_we, prog_ba, prog_addr, prog_data, prog_mask, dwnld_busy} !==
        {1'b1, 2'd0, 23'd2, 16'h3C3C, 2'b10, 1'b1}) begin
      fails++;
      $display("FAIL flush_write: got we=%b ba=%0d addr=%h data=%h mask=%b busy=%b required 1 0 2 3c3c 10 1",
               prog_we, prog_ba, prog_addr, prog_data, prog_mask, dwnld_busy);
    end
    ack();
    checks++;
    if ({prog_we, dwnld_busy} !== 2'b00) begin
      fails++; $display("FAIL flush_busy_fall: got we=%b busy=%b required 0 0", prog_we, dwnld_busy);
    end
  endtask

  task automatic test_bank1;
    bit ok;
    downloading = 1'b1;
    strobe(25'h10_0000, 8'h11);
    strobe(25'h10_0001, 8'h22);
    wait_we(ok);
    checks++;
    if (!ok || {prog_ba, prog_addr, prog_data, prog_mask} !== {2'd1, 23'd0, 16'h2211, 2'b00}) begin
      fails++;
      $display("FAIL bank1_pair: got we=%b ba=%0d addr=%h data=%h mask=%b required 1 1 0 2211 00",
               prog_we, prog_ba, prog_addr, prog_data, prog_mask);
    end
    ack();
    strobe(25'h10_0001, 8'h33);
    downloading = 1'b0;
    wait_we(ok);
    checks++;
    if (!ok || {prog_ba, prog_addr, prog_data, prog_mask} !== {2'd1, 23'd0, 16'h3333, 2'b01}) begin
      fails++;
      $display("FAIL bank1_odd: got we=%b ba=%0d addr=%h data=%h mask=%b required 1 1 0 3333 01",
               prog_we, prog_ba, prog_addr, prog_data, prog_mask);
    end
    ack();
  endtask

  task automatic test_overflow;
    bit ok;
    int bad_stall;
    logic [7:0] k8;
    bad_stall = 0;
    downloading = 1'b1;
    prog_rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      k8 = 8'(k);
      strobe(25'h40 + 25'(2*k), k8);
      if (k >= 1) begin
        checks++;
        if ({prog_we, prog_addr} !== {1'b1, 23'h20}) begin
          fails++; $display("FAIL stall_stable_even: got we=%b addr=%h required 1 20", prog_we, prog_addr);
        end
      end
      strobe(25'h41 + 25'(2*k), 8'h80 | k8);
      if (k >= 1) begin
        checks++;
        if ({prog_we, prog_addr} !== {1'b1, 23'h20}) begin
          fails++; $display("FAIL stall_stable_odd: got we=%b addr=%h required 1 20", prog_we, prog_addr);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if ({prog_we, prog_addr, prog_data} !== {1'b1, 23'h20, 16'h8000}) bad_stall++;
    end
    checks++;
    if (bad_stall != 0) begin
      fails++; $display("FAIL stall_hold: got %0d unstable cycles required 0", bad_stall);
    end
    checks++;
    if (overflow !== 1'b1) begin
      fails++; $display("FAIL overflow_flag: got %b required 1", overflow);
    end
    for (int k = 0; k < 5; k++) begin
      k8 = 8'(k);
      wait_we(ok);
      checks++;
      if (!ok || {prog_ba, prog_addr, prog_data, prog_mask} !== {2'd0, 23'h20 + 23'(k), 8'h80 | k8, k8, 2'b00}) begin
        fails++;
        $display("FAIL drain_word%0d: got we=%b ba=%0d addr=%h data=%h mask=%b required 1 0 %h %h 00",
                 k, prog_we, prog_ba, prog_addr, prog_data, prog_mask, 23'h20 + 23'(k), {8'h80 | k8, k8});
      end
      ack();
    end
    wait_we(ok);
    checks++;
    if (ok) begin
      fails++; $display("FAIL drain_extra: got unexpected write addr=%h required none", prog_addr);
      ack();
    end
  endtask

  task automatic test_gaps;
    bit ok;
    logic [22:0] exp_addr [3];
    logic [15:0] exp_data [3];
    logic [1:0]  exp_mask [3];
    exp_addr[0] = 23'd8;  exp_data[0] = 16'hA1A1; exp_mask[0] = 2'b10;
    exp_addr[1] = 23'd9;  exp_data[1] = 16'hB2B2; exp_mask[1] = 2'b01;
    exp_addr[2] = 23'd16; exp_data[2] = 16'hC3C3; exp_mask[2] = 2'b10;
    downloading = 1'b1;
    strobe(25'h10, 8'hA1);
    strobe(25'h13, 8'hB2);
    strobe(25'h20, 8'hC3);
    downloading = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_we(ok);
      checks++;
      if (!ok || {prog_ba, prog_addr, prog_data, prog_mask} !== {2'd0, exp_addr[i], exp_data[i], exp_mask[i]}) begin
        fails++;
        $display("FAIL gap_write%0d: got we=%b ba=%0d addr=%h data=%h mask=%b required 1 0 %h %h %b",
                 i, prog_we, prog_ba, prog_addr, prog_data, prog_mask, exp_addr[i], exp_data[i], exp_mask[i]);
      end
      ack();
    end
  endtask

  task automatic test_reset_in_wait;
    int stray;
    stray = 0;
    downloading = 1'b1;
    prog_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      strobe(25'h80 + 25'(2*k), 8'(k));
      strobe(25'h81 + 25'(2*k), 8'(k + 8));
    end
    checks++;
    if (prog_we !== 1'b1) begin
      fails++; $display("FAIL rstwait_pre_we: got %b required 1", prog_we);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({prog_we, dwnld_busy, overflow, prog_mask} !== {1'b0, downloading, 1'b0, 2'b11}) begin
      fails++;
      $display("FAIL rstwait_after: got we=%b busy=%b ovf=%b mask=%b required 0 %b 0 11",
               prog_we, dwnld_busy, overflow, prog_mask, downloading);
    end
    rst = 1'b0;
    downloading = 1'b0;
    tick();
    checks++;
    if (dwnld_busy !== 1'b0) begin
      fails++; $display("FAIL rstwait_busy: got %b required 0", dwnld_busy);
    end
    prog_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (prog_we !== 1'b0) stray++;
    end
    prog_rdy = 1'b0;
    checks++;
    if (stray != 0) begin
      fails++; $display("FAIL rstwait_no_writes: got %0d write cycles required 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_merge();
    test_flush();
    test_bank1();
    test_overflow();
    test_gaps();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
